// File: rtl/lrc_pkg.sv
// rtl/lrc_pkg.sv - shared constants and FSM state type for the LRC arbiter
package lrc_pkg;

    localparam int DATA_W  = 8;
    localparam int LEN_W   = 8;
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_RESULT = 2'd2
    } lrc_state_t;

endpackage

// File: rtl/lrc_acc.sv
// rtl/lrc_acc.sv - modulo-2^DATA_W byte accumulator producing the LRC (LRC_CHECK_EN adds a payload-only LRC)
module lrc_acc #(
    parameter int DATA_W = lrc_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
`ifdef LRC_CHECK_EN
    output logic [DATA_W-1:0] sum,
`endif
    output logic [DATA_W-1:0] lrc
);

    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sum_q <= '0;
        end else if (en) begin
            sum_q <= sum_q + data;
        end
    end

`ifdef LRC_CHECK_EN
    // Sum before the most recent byte: once the check byte lands, this is the payload sum.
    logic [DATA_W-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            prev_q <= '0;
        end else if (en) begin
            prev_q <= sum_q;
        end
    end

    assign sum = sum_q;
    assign lrc = -prev_q;
`else
    assign lrc = -sum_q;
`endif

endmodule

// File: rtl/lrc_arbiter.sv
// rtl/lrc_arbiter.sv - two-requester round-robin frame arbiter sharing one LRC accumulator (option: LRC_CHECK_EN)
module lrc_arbiter #(
    parameter int DATA_W = lrc_pkg::DATA_W,
    parameter int LEN_W  = lrc_pkg::LEN_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [lrc_pkg::NUM_REQ-1:0]          req_valid,
    input  logic [lrc_pkg::NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [lrc_pkg::NUM_REQ-1:0]          req_last,
    output logic [lrc_pkg::NUM_REQ-1:0]          req_ready,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic                                 res_id,
    output logic [DATA_W-1:0]                    res_lrc,
    output logic [LEN_W-1:0]                     res_len,
    output logic                                 res_ovf,
    output logic                                 res_bad
);

    import lrc_pkg::*;

    lrc_state_t        state_q, state_d;
    logic              grant_q, ptr_q, ovf_q;
    logic [LEN_W-1:0]  len_q;
    logic              winner, acc_clr, acc_en, byte_last;
    logic [DATA_W-1:0] byte_data, acc_lrc;

    // Pointer only matters on a tie; a lone requester always wins.
    assign winner    = (&req_valid) ? ptr_q : req_valid[1];
    assign byte_data = grant_q ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
    assign byte_last = grant_q ? req_last[1] : req_last[0];

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        res_valid = 1'b0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    state_d = ST_BUSY;
                    acc_clr = 1'b1;
                end
            end
            ST_BUSY: begin
                req_ready[grant_q] = 1'b1;
                if (req_valid[grant_q]) begin
                    acc_en = 1'b1;
                    if (byte_last) state_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            ptr_q   <= 1'b0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && (|req_valid)) begin
                grant_q <= winner;
                len_q   <= '0;
                ovf_q   <= 1'b0;
            end
            if (acc_en) begin
                len_q <= len_q + 1'b1;
                if (&len_q) ovf_q <= 1'b1;
            end
            if (state_q == ST_RESULT && res_ready) ptr_q <= ~grant_q;
        end
    end

`ifdef LRC_CHECK_EN
    logic [DATA_W-1:0] acc_sum;

    lrc_acc #(.DATA_W(DATA_W)) u_acc (
        .clk  (clk),
        .rst  (rst),
        .clr  (acc_clr),
        .en   (acc_en),
        .data (byte_data),
        .sum  (acc_sum),
        .lrc  (acc_lrc)
    );

    assign res_bad = (acc_sum != '0);
`else
    lrc_acc #(.DATA_W(DATA_W)) u_acc (
        .clk  (clk),
        .rst  (rst),
        .clr  (acc_clr),
        .en   (acc_en),
        .data (byte_data),
        .lrc  (acc_lrc)
    );

    assign res_bad = 1'b0;
`endif

    // Result fields come straight from registers frozen while in RESULT.
    assign res_id  = grant_q;
    assign res_lrc = acc_lrc;
    assign res_len = len_q;
    assign res_ovf = ovf_q;

endmodule

// File: tb/tb_lrc_arbiter.sv
// tb/tb_lrc_arbiter.sv - scoreboard bench for lrc_arbiter (frames of LRC_CHECK_EN added when defined)
module tb_lrc_arbiter;

    typedef struct {
        logic       id;
        logic [7:0] lrc;
        logic [7:0] len;
        logic       ovf;
        logic       bad;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_last, req_ready;
    logic [15:0] req_data;
    logic        res_valid, res_ready, res_id, res_ovf, res_bad;
    logic [7:0]  res_lrc, res_len;

    logic        v0, v1, l0, l1, rr;
    logic [7:0]  d0, d1;
    logic [8:0]  txq0[$], txq1[$];
    logic [7:0]  fb[$];
    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    assign req_valid = {v1, v0};
    assign req_last  = {l1, l0};
    assign req_data  = {d1, d0};
    assign res_ready = rr;

    always #5 clk = ~clk;

    lrc_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_lrc   (res_lrc),
        .res_len   (res_len),
        .res_ovf   (res_ovf),
        .res_bad   (res_bad)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: builds the expected result from the bytes in fb and queues the bytes.
    task automatic queue_frame(input int r);
        exp_t e;
        int   sum_all, sum_pay, n;
        n = fb.size();
        sum_all = 0;
        sum_pay = 0;
        for (int i = 0; i < n; i++) begin
            sum_all += fb[i];
`ifdef LRC_CHECK_EN
            if (i != n - 1) sum_pay += fb[i];
`else
            sum_pay += fb[i];
`endif
            if (r == 0) txq0.push_back({(i == n - 1), fb[i]});
            else        txq1.push_back({(i == n - 1), fb[i]});
        end
        e.id  = (r != 0);
        e.lrc = 8'((256 - (sum_pay % 256)) % 256);
        e.len = 8'(n % 256);
        e.ovf = (n > 255);
`ifdef LRC_CHECK_EN
        e.bad = ((sum_all % 256) != 0);
`else
        e.bad = 1'b0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_req_ready"}, req_ready, 0);
        check_eq({tag, "_res_valid"}, res_valid, 0);
        check_eq({tag, "_res_id"},    res_id,    0);
        check_eq({tag, "_res_lrc"},   res_lrc,   0);
        check_eq({tag, "_res_len"},   res_len,   0);
        check_eq({tag, "_res_ovf"},   res_ovf,   0);
        check_eq({tag, "_res_bad"},   res_bad,   0);
    endtask

    task automatic wait_drain(input int max_cycles);
        int k;
        for (k = 0; k < max_cycles; k++) begin
            @(posedge clk); #2;
            if (exp_q.size() == 0 && txq0.size() == 0 && txq1.size() == 0 && !res_valid) break;
        end
        if (k == max_cycles) check_eq("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin : drv0
        logic a0;
        v0 = 1'b0; d0 = '0; l0 = 1'b0;
        forever begin
            @(negedge clk);
            a0 = v0 && req_ready[0] && !rst;
            @(posedge clk); #1;
            if (a0 && txq0.size() > 0) void'(txq0.pop_front());
            if (txq0.size() > 0) begin
                v0 = 1'b1; d0 = txq0[0][7:0]; l0 = txq0[0][8];
            end else begin
                v0 = 1'b0; d0 = '0; l0 = 1'b0;
            end
        end
    end

    initial begin : drv1
        logic a1;
        v1 = 1'b0; d1 = '0; l1 = 1'b0;
        forever begin
            @(negedge clk);
            a1 = v1 && req_ready[1] && !rst;
            @(posedge clk); #1;
            if (a1 && txq1.size() > 0) void'(txq1.pop_front());
            if (txq1.size() > 0) begin
                v1 = 1'b1; d1 = txq1[0][7:0]; l1 = txq1[0][8];
            end else begin
                v1 = 1'b0; d1 = '0; l1 = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic prev_last;
        exp_t e;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_last) check_eq("res_valid_latency", res_valid, 1);
                if (req_ready != 2'b00) check_eq("ready_onehot", (req_ready == 2'b11), 0);
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_result", res_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("res_id",  res_id,  e.id);
                        check_eq("res_lrc", res_lrc, e.lrc);
                        check_eq("res_len", res_len, e.len);
                        check_eq("res_ovf", res_ovf, e.ovf);
                        check_eq("res_bad", res_bad, e.bad);
                    end
                end
            end
            prev_last = !rst && ((req_valid & req_ready & req_last) != 2'b00);
        end
    end

    initial begin : main
        logic [7:0] s_lrc, s_len;
        logic       s_id;
        int         k, cnt;
        rst = 1'b1;
        rr  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk); #2;
        rst = 1'b0;

        // contention straight out of reset: requester 0 wins, then 1
        @(posedge clk); #2;
        fb = {8'h10, 8'h20}; queue_frame(0);
        fb = {8'h05, 8'h05}; queue_frame(1);
        wait_drain(100);

        fb = {8'h01, 8'h02, 8'h03}; queue_frame(0);
        wait_drain(100);

        // backpressure: pointer is now 1, so requester 1 goes first
        rr = 1'b0;
        fb = {8'hAA, 8'h55, 8'h0F}; queue_frame(1);
        fb = {8'h33};               queue_frame(0);
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (res_valid) break;
        end
        check_eq("bp_res_valid", res_valid, 1);
        s_id = res_id; s_lrc = res_lrc; s_len = res_len;
        repeat (5) begin
            @(negedge clk);
            check_eq("bp_hold_valid", res_valid, 1);
            check_eq("bp_hold_id",    res_id,    s_id);
            check_eq("bp_hold_lrc",   res_lrc,   s_lrc);
            check_eq("bp_hold_len",   res_len,   s_len);
            check_eq("bp_no_grant",   req_ready, 0);
        end
        @(posedge clk); #2;
        rr = 1'b1;
        wait_drain(100);

        fb.delete();
        for (int i = 0; i < 256; i++) fb.push_back(8'h01);
        queue_frame(1);
        wait_drain(600);

        fb = {8'h11, 8'h22}; queue_frame(0);
        wait_drain(100);

        // reset after two of four bytes; pointer was 1 and must return to 0
        txq0.push_back({1'b0, 8'hA1});
        txq0.push_back({1'b0, 8'hA2});
        txq0.push_back({1'b0, 8'hA3});
        txq0.push_back({1'b1, 8'hA4});
        cnt = 0;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (req_valid[0] && req_ready[0]) cnt++;
            if (cnt == 2) break;
        end
        check_eq("midrst_accepts", cnt, 2);
        @(posedge clk); #2;
        rst = 1'b1;
        txq0.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check_zero_outputs("midrst");
        @(posedge clk); #2;
        fb = {8'h7F}; queue_frame(0);
        fb = {8'h01}; queue_frame(1);
        wait_drain(100);

`ifdef LRC_CHECK_EN
        fb = {8'h10, 8'h20, 8'hD0}; queue_frame(0);
        fb = {8'h10, 8'h20, 8'hD1}; queue_frame(0);
        wait_drain(100);
`endif

        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
